// File: rtl/instruction_queue_pkg.sv
// Shared widths and defaults for the UART-to-core instruction queue.
package instruction_queue_pkg;
   localparam int INSTR_W             = 32;
   localparam int DEFAULT_QUEUE_DEPTH = 4;
endpackage

// File: rtl/instruction_queue.sv
// FIFO between the UART instruction receiver and the core injection port.
// Optional sticky drop flag enabled by INSTRUCTION_QUEUE_OVERFLOW_EN.
module instruction_queue
   import instruction_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
   input  logic                       clk12,
   input  logic                       rst,
   input  logic [INSTR_W-1:0]         instruction,
   input  logic                       instruction_rcv,
   output logic [INSTR_W-1:0]         instr_data,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               pop;
   logic               push_ok;

   assign instr_valid = (count != '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign pop         = instr_valid & instr_ready;
   // A full queue still accepts when the head leaves in the same cycle.
   assign push_ok     = instruction_rcv & (~full | pop);
   assign instr_data  = mem[rd_ptr];

   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok) begin
         mem[wr_ptr] <= instruction;
      end
   end

   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef INSTRUCTION_QUEUE_OVERFLOW_EN
   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (instruction_rcv & ~push_ok) begin
         overflow <= 1'b1;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: scoreboard of expected words checked by an output monitor.
module tb_instruction_queue;
   import instruction_queue_pkg::*;

   localparam int DEPTH = 4;

`ifdef INSTRUCTION_QUEUE_OVERFLOW_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic               clk12 = 1'b0;
   logic               rst;
   logic [INSTR_W-1:0] instruction;
   logic               instruction_rcv;
   logic [INSTR_W-1:0] instr_data;
   logic               instr_valid;
   logic               instr_ready;
   logic [2:0]         count;
   logic               full;
   logic               overflow;

   int vectors     = 0;
   int miscompares = 0;
   logic [INSTR_W-1:0] sb [$];
   logic [INSTR_W-1:0] exp_word;

   instruction_queue #(.DEPTH(DEPTH)) dut (
      .clk12          (clk12),
      .rst            (rst),
      .instruction    (instruction),
      .instruction_rcv(instruction_rcv),
      .instr_data     (instr_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .count          (count),
      .full           (full),
      .overflow       (overflow)
   );

   always #5 clk12 = ~clk12;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted head transfer must match the scoreboard front.
   initial begin
      forever begin
         @(negedge clk12);
         if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", instr_data, 32'hFFFF_FFFF);
            end else begin
               exp_word = sb.pop_front();
               chk("output_word", instr_data, exp_word);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk12);
      #1;
   endtask

   task automatic drive(input logic rcv, input logic [31:0] word, input logic rdy);
      instruction_rcv = rcv;
      instruction     = word;
      instr_ready     = rdy;
   endtask

   logic [31:0] burst [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
   logic [31:0] wrapw [6] = '{32'hA0000001, 32'hA0000002, 32'hA0000003,
                              32'hA0000004, 32'hA0000005, 32'hA0000006};

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      repeat (3) cycle();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_data", instr_data, 32'h0);
      rst = 1'b0;
      cycle();

      // Single push then single pop
      drive(1'b1, 32'h00100093, 1'b0);
      sb.push_back(32'h00100093);
      cycle();
      drive(1'b0, 32'h0, 1'b0);
      chk("single_valid", 32'(instr_valid), 32'd1);
      chk("single_data", instr_data, 32'h00100093);
      chk("single_count", 32'(count), 32'd1);
      instr_ready = 1'b1;
      cycle();
      instr_ready = 1'b0;
      chk("single_valid_after_pop", 32'(instr_valid), 32'd0);
      chk("single_count_after_pop", 32'(count), 32'd0);

      // Fill to full while stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, burst[i], 1'b0);
         sb.push_back(burst[i]);
         cycle();
      end
      drive(1'b0, 32'h0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_head", instr_data, 32'h11111111);
      chk("fill_overflow", 32'(overflow), 32'd0);

      // Push into full queue without pop: dropped
      drive(1'b1, 32'hDEADBEEF, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 1'b0);
      chk("drop_count", 32'(count), 32'd4);
      chk("drop_head", instr_data, 32'h11111111);
      chk("drop_overflow", 32'(overflow), 32'(OVF_EXP));

      // Push into full queue with simultaneous pop: accepted
      drive(1'b1, 32'h55555555, 1'b1);
      sb.push_back(32'h55555555);
      cycle();
      drive(1'b0, 32'h0, 1'b0);
      chk("pushpop_count", 32'(count), 32'd4);
      chk("pushpop_full", 32'(full), 32'd1);
      chk("pushpop_overflow", 32'(overflow), 32'(OVF_EXP));
      chk("pushpop_head", instr_data, 32'h22222222);

      instr_ready = 1'b1;
      repeat (4) cycle();
      instr_ready = 1'b0;
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(instr_valid), 32'd0);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);

      // Streaming with ready held high, pointers wrap
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, wrapw[i], 1'b1);
         sb.push_back(wrapw[i]);
         cycle();
         chk("stream_count", 32'(count), 32'd1);
      end
      drive(1'b0, 32'h0, 1'b1);
      cycle();
      chk("stream_final_count", 32'(count), 32'd0);
      chk("stream_overflow", 32'(overflow), 32'(OVF_EXP));
      chk("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset mid-stream with three entries
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hC0000000 + 32'(i), 1'b0);
         sb.push_back(32'hC0000000 + 32'(i));
         cycle();
      end
      drive(1'b0, 32'h0, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_valid", 32'(instr_valid), 32'd0);
      chk("async_rst_full", 32'(full), 32'd0);
      chk("async_rst_overflow", 32'(overflow), 32'd0);
      chk("async_rst_data", instr_data, 32'h0);
      cycle();
      rst = 1'b0;
      cycle();

      drive(1'b1, 32'h00000013, 1'b0);
      sb.push_back(32'h00000013);
      cycle();
      drive(1'b0, 32'h0, 1'b0);
      chk("post_rst_head", instr_data, 32'h00000013);
      chk("post_rst_count", 32'(count), 32'd1);
      instr_ready = 1'b1;
      cycle();
      instr_ready = 1'b0;
      cycle();
      chk("final_count", 32'(count), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
